// File: rtl/fetch_unit.sv
// Instruction fetch: loadable imem, PC with 4-way next-PC select, run-control FSM, registered IF/ID.
// One-cycle fetch latency; i_stall_pc_HD holds PC and IF/ID, step mode without i_step inserts bubbles.
module fetch_unit #(
  parameter int                 INST_SZ   = 32,
  parameter int                 PC_SZ     = 32,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [PC_SZ-1:0]   RESET_PC  = '0,
  parameter logic [INST_SZ-1:0] HALT_INST = 32'hFFFF_FFFF,
  parameter logic [INST_SZ-1:0] NOP_INST  = 32'h0000_0000,
  localparam int                AW        = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_en,
  input  logic [INST_SZ-1:0] i_load_data,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic [PC_SZ-1:0]   i_branch_addr_D,
  input  logic [PC_SZ-1:0]   i_jump_addr_D,
  input  logic [PC_SZ-1:0]   i_rs_addr_D,
  input  logic               i_pc_src_D,
  input  logic               i_jump_D,
  input  logic               i_jump_sel_D,
  input  logic               i_stall_pc_HD,
  input  logic               i_flush_D,
  output logic [PC_SZ-1:0]   o_pc_F,
  output logic [PC_SZ-1:0]   o_npc_F,
  output logic [INST_SZ-1:0] o_instruction_F,
  output logic               o_valid_F,
  output logic               o_halt,
  output logic [AW:0]        o_load_cnt,
  output logic               o_load_full,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [PC_SZ-1:0]   pc, pc_nxt;
  logic [PC_SZ-1:0]   pc_f_nxt, npc_f_nxt, target;
  logic [INST_SZ-1:0] inst_nxt, fetched;
  logic               valid_nxt, load_we;
  logic [AW:0]        load_cnt_nxt;
  logic [AW-1:0]      idx;
  logic [INST_SZ-1:0] mem [MEM_DEPTH];
  logic               unused_pc_bits;

  assign idx            = pc[AW+1:2];
  assign unused_pc_bits = ^{pc[1:0], pc[PC_SZ-1:AW+2]};
  // Words beyond the loaded program read as HALT so stale memory never executes.
  assign fetched        = ({1'b0, idx} >= o_load_cnt) ? HALT_INST : mem[idx];
  assign o_load_full    = (o_load_cnt == (AW+1)'(MEM_DEPTH));
  assign o_halt         = (state == ST_HALTED);
  assign o_state        = state;

  always_comb begin
    if (i_jump_sel_D)    target = i_rs_addr_D;
    else if (i_jump_D)   target = i_jump_addr_D;
    else if (i_pc_src_D) target = i_branch_addr_D;
    else                 target = pc + PC_SZ'(4);
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pc_f_nxt     = o_pc_F;
    npc_f_nxt    = o_npc_F;
    inst_nxt     = o_instruction_F;
    valid_nxt    = o_valid_F;
    load_we      = 1'b0;
    load_cnt_nxt = o_load_cnt;
    case (state)
      ST_IDLE: begin
        if (i_load_en && !o_load_full) begin
          load_we      = 1'b1;
          load_cnt_nxt = o_load_cnt + 1'b1;
        end
        if (i_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_stall_pc_HD) begin
          // full hold, including the valid flag
        end else if (i_step_mode && !i_step) begin
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b0;
        end else if (i_flush_D) begin
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b0;
          pc_f_nxt  = pc;
          npc_f_nxt = pc + PC_SZ'(4);
          pc_nxt    = target;
        end else if (fetched == HALT_INST) begin
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b0;
          state_nxt = ST_HALTED;
        end else begin
          inst_nxt  = fetched;
          valid_nxt = 1'b1;
          pc_f_nxt  = pc;
          npc_f_nxt = pc + PC_SZ'(4);
          pc_nxt    = target;
        end
      end
      ST_HALTED: begin
        inst_nxt  = NOP_INST;
        valid_nxt = 1'b0;
        if (i_start) begin
          state_nxt = ST_IDLE;
          pc_nxt    = RESET_PC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      pc              <= RESET_PC;
      o_pc_F          <= '0;
      o_npc_F         <= '0;
      o_instruction_F <= NOP_INST;
      o_valid_F       <= 1'b0;
      o_load_cnt      <= '0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      o_pc_F          <= pc_f_nxt;
      o_npc_F         <= npc_f_nxt;
      o_instruction_F <= inst_nxt;
      o_valid_F       <= valid_nxt;
      o_load_cnt      <= load_cnt_nxt;
    end
  end

  // Memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge i_clk) begin
    if (load_we) mem[o_load_cnt[AW-1:0]] <= i_load_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, run, redirect, stall, flush, step, halt, fill and async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, start, step_mode, step;
  logic [31:0] load_data, branch_addr, jump_addr, rs_addr;
  logic        pc_src, jump, jump_sel, stall, flush;
  logic [31:0] pc_f, npc_f, inst_f;
  logic        valid_f, halt, load_full;
  logic [8:0]  load_cnt;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .i_clk(clk), .i_reset(rst),
    .i_load_en(load_en), .i_load_data(load_data),
    .i_start(start), .i_step_mode(step_mode), .i_step(step),
    .i_branch_addr_D(branch_addr), .i_jump_addr_D(jump_addr), .i_rs_addr_D(rs_addr),
    .i_pc_src_D(pc_src), .i_jump_D(jump), .i_jump_sel_D(jump_sel),
    .i_stall_pc_HD(stall), .i_flush_D(flush),
    .o_pc_F(pc_f), .o_npc_F(npc_f), .o_instruction_F(inst_f), .o_valid_F(valid_f),
    .o_halt(halt), .o_load_cnt(load_cnt), .o_load_full(load_full), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    load_en   = 1'b1;
    load_data = w;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
    check({tag, "_pc"}, pc_f, pc);
    check({tag, "_inst"}, inst_f, ins);
    check({tag, "_valid"}, {31'd0, valid_f}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; load_en = 0; load_data = 0; start = 0; step_mode = 0; step = 0;
    branch_addr = 0; jump_addr = 0; rs_addr = 0;
    pc_src = 0; jump = 0; jump_sel = 0; stall = 0; flush = 0;
    #12 rst = 1'b0;
    tick();

    // reset state
    chk_out("rst", 32'h0, 32'h0, 1'b0);
    check("rst_npc", npc_f, 32'h0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_cnt", {23'd0, load_cnt}, 32'd0);

    // four-word program ending in HALT
    load_word(32'h2001_0005);
    load_word(32'h2002_0003);
    load_word(32'h0022_1820);
    load_word(32'hFFFF_FFFF);
    check("p1_cnt", {23'd0, load_cnt}, 32'd4);
    start = 1'b1; tick(); start = 1'b0;
    check("p1_state_run", {30'd0, state}, 32'd1);
    tick(); chk_out("p1_w0", 32'h0, 32'h2001_0005, 1'b1);
    check("p1_npc0", npc_f, 32'h4);
    tick(); chk_out("p1_w1", 32'h4, 32'h2002_0003, 1'b1);
    tick(); chk_out("p1_w2", 32'h8, 32'h0022_1820, 1'b1);
    tick();
    check("p1_halt", {31'd0, halt}, 32'd1);
    check("p1_state_h", {30'd0, state}, 32'd2);
    check("p1_halt_valid", {31'd0, valid_f}, 32'd0);
    check("p1_halt_inst", inst_f, 32'h0);
    load_word(32'h1234_5678);
    check("p1_halt_noload", {23'd0, load_cnt}, 32'd4);
    check("p1_halt_hold", {31'd0, halt}, 32'd1);

    // two-word program without HALT; start coincides with the last load
    rst = 1'b1; #2 rst = 1'b0;
    load_word(32'h1111_1111);
    load_en = 1'b1; load_data = 32'h2222_2222; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("p2_cnt", {23'd0, load_cnt}, 32'd2);
    check("p2_state_run", {30'd0, state}, 32'd1);
    tick(); chk_out("p2_w0", 32'h0, 32'h1111_1111, 1'b1);
    tick(); chk_out("p2_w1", 32'h4, 32'h2222_2222, 1'b1);
    tick();
    check("p2_state_h", {30'd0, state}, 32'd2);
    check("p2_valid", {31'd0, valid_f}, 32'd0);

    // back to IDLE, append words 2..47 as A000_0000 + index
    start = 1'b1; tick(); start = 1'b0;
    check("p3_state_idle", {30'd0, state}, 32'd0);
    check("p3_cnt_kept", {23'd0, load_cnt}, 32'd2);
    for (int i = 2; i < 48; i++) load_word(32'hA000_0000 + i);
    check("p3_cnt", {23'd0, load_cnt}, 32'd48);
    start = 1'b1; tick(); start = 1'b0;

    // jump_sel beats jump
    jump_sel = 1'b1; rs_addr = 32'h40; jump = 1'b1; jump_addr = 32'h80;
    tick();
    jump_sel = 1'b0; jump = 1'b0;
    chk_out("j_w0", 32'h0, 32'h1111_1111, 1'b1);
    tick(); chk_out("j_tgt", 32'h40, 32'hA000_0010, 1'b1);

    // branch
    pc_src = 1'b1; branch_addr = 32'h80;
    tick();
    pc_src = 1'b0;
    chk_out("b_w", 32'h44, 32'hA000_0011, 1'b1);
    tick(); chk_out("b_tgt", 32'h80, 32'hA000_0020, 1'b1);
    check("b_npc", npc_f, 32'h84);

    // 3-cycle stall holds everything
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_out("stall", 32'h80, 32'hA000_0020, 1'b1);
    end
    stall = 1'b0;
    tick(); chk_out("resume", 32'h84, 32'hA000_0021, 1'b1);

    // flush at 0x88 turns the fetch into a bubble
    flush = 1'b1; tick(); flush = 1'b0;
    chk_out("flush", 32'h88, 32'h0, 1'b0);
    check("flush_npc", npc_f, 32'h8C);
    tick(); chk_out("post_flush", 32'h8C, 32'hA000_0023, 1'b1);

    // step mode, pulse every 4th cycle
    step_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step = (k % 4 == 0);
      tick();
      if (k % 4 == 0)
        chk_out("step_v", 32'h90 + 4 * (k / 4), 32'hA000_0024 + (k / 4), 1'b1);
      else begin
        check("step_b_inst", inst_f, 32'h0);
        check("step_b_valid", {31'd0, valid_f}, 32'd0);
      end
    end
    step = 1'b0; step_mode = 1'b0;

    // fill past MEM_DEPTH, then async reset in RUN
    rst = 1'b1; #2 rst = 1'b0;
    for (int i = 0; i < 257; i++) load_word(32'h0100_0000 + i);
    check("full_cnt", {23'd0, load_cnt}, 32'd256);
    check("full_flag", {31'd0, load_full}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_out("full_run", 32'h4, 32'h0100_0001, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("arst", 32'h0, 32'h0, 1'b0);
    check("arst_npc", npc_f, 32'h0);
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_cnt", {23'd0, load_cnt}, 32'd0);
    check("arst_halt", {31'd0, halt}, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the MIPS pipeline. It contains a loadable instruction memory with a sequential loader, a PC with four-way next-PC selection, and a registered IF/ID output. It also adds a run-control state machine with three states: idle/load, run, and halted. Run mode supports single-step, flush-to-bubble and halt-instruction detection. It sits between the debug loader and the decode stage, and takes its redirect, stall and flush inputs from decode and the hazard unit.

## Interface
- INST_SZ, 32, instruction width
- PC_SZ, 32, PC width (byte address)
- MEM_DEPTH, 256, instruction memory words (power of 2); AW = clog2(MEM_DEPTH)
- RESET_PC, 0, PC value after reset and after restart
- HALT_INST, 32'hFFFF_FFFF, halt encoding
- NOP_INST, 32'h0000_0000, bubble encoding
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_load_en  in  1  write i_load_data to the next memory word (IDLE only)
- i_load_data  in  INST_SZ  instruction to load
- i_start  in  1  IDLE->RUN; HALTED->IDLE
- i_step_mode  in  1  1 = advance only on i_step
- i_step  in  1  single-cycle step pulse
- i_branch_addr_D, i_jump_addr_D, i_rs_addr_D  in  PC_SZ  redirect targets
- i_pc_src_D, i_jump_D, i_jump_sel_D  in  1  redirect selects
- i_stall_pc_HD  in  1  hold PC and IF/ID register
- i_flush_D  in  1  replace the fetched instruction with a bubble
- o_pc_F  out  PC_SZ  PC of the registered instruction
- o_npc_F  out  PC_SZ  o_pc_F + 4
- o_instruction_F  out  INST_SZ  registered instruction
- o_valid_F  out  1  o_instruction_F is a real instruction
- o_halt  out  1  state == HALTED
- o_load_cnt  out  AW+1  number of words loaded
- o_load_full  out  1  o_load_cnt == MEM_DEPTH
- o_state  out  2  00 IDLE, 01 RUN, 10 HALTED

## Operation
- Reset (asynchronous, any state) sets:
  - pc = RESET_PC, o_pc_F = 0, o_npc_F = 0
  - o_instruction_F = NOP_INST, o_valid_F = 0
  - o_load_cnt = 0, state = IDLE, o_halt = 0
  - Memory contents are not cleared.
- IDLE:
  - i_load_en with !o_load_full writes mem[o_load_cnt] and increments o_load_cnt.
  - i_load_en while full is ignored; the count saturates at MEM_DEPTH.
  - i_start -> RUN. Simultaneous load and start: the load completes and the word counts.
- RUN:
  - Advance condition: adv = !i_stall_pc_HD && (!i_step_mode || i_step).
  - Fetch word: index = pc[AW+1:2]. If index >= o_load_cnt, the fetch returns HALT_INST (unloaded memory is never executed).
  - Next PC priority: i_jump_sel_D -> i_rs_addr_D; else i_jump_D -> i_jump_addr_D; else i_pc_src_D -> i_branch_addr_D; else pc+4. Arithmetic is modulo 2^PC_SZ.
  - Redirect inputs are sampled only on adv.
  - On adv with i_flush_D:
    - o_instruction_F = NOP_INST, o_valid_F = 0, o_pc_F/o_npc_F updated.
    - pc = next PC.
    - Halt check is suppressed.
  - On adv with fetched word == HALT_INST (no flush):
    - o_instruction_F = NOP_INST, o_valid_F = 0.
    - pc is held at the halt address; state -> HALTED.
  - On adv otherwise: o_instruction_F = fetched word, o_pc_F = pc, o_npc_F = pc+4, o_valid_F = 1, pc = next PC.
  - !adv due to i_stall_pc_HD: pc and all IF/ID outputs hold, including o_valid_F.
  - !adv due to step mode without i_step: pc holds; IF/ID is loaded with NOP_INST and o_valid_F = 0 (bubble).
  - Stall has priority over step: a step pulse during a stall is lost.
- HALTED:
  - IF/ID is loaded with a bubble each cycle; o_halt = 1.
  - i_start -> IDLE with pc = RESET_PC. o_load_cnt is kept, so the program can be rerun or appended to.
- i_load_en in RUN or HALTED is ignored.

## Timing
- Memory read is combinational from pc; IF/ID outputs are registered, giving 1-cycle fetch latency.
- An instruction at address A is on o_instruction_F the cycle after pc == A with adv.
- A redirect presented with adv in cycle n gives pc = target in n+1 and the target instruction on the outputs in n+2.
- State transitions take effect on the clock edge; o_state and o_halt are registered.
- HALTED is visible the cycle after the halt fetch.
- Reset mid-RUN forces IDLE and bubble outputs immediately, without waiting for a clock.

## Test plan
- Load 4 words (0x20010005, 0x20020003, 0x00221820, HALT), then start:
  - o_instruction_F shows the three words on consecutive cycles with o_pc_F 0, 4, 8 and o_valid_F = 1.
  - o_halt rises on cycle 5; pc stays 12.
- Load 2 words only, no HALT: after 2 valid fetches, fetch index 2 >= o_load_cnt gives HALTED; o_valid_F = 0.
- i_jump_sel_D = 1 with i_rs_addr_D = 0x40, and i_jump_D = 1 with i_jump_addr_D = 0x80, same cycle: next o_pc_F = 0x40 (jump_sel wins).
- i_stall_pc_HD high for 3 cycles: o_pc_F, o_instruction_F and o_valid_F are unchanged; the fetch resumes at the held pc.
- Step mode with i_step every 4th cycle: exactly one valid instruction per pulse, with bubbles (NOP, valid 0) in between.
- Load MEM_DEPTH+1 words: o_load_full = 1 and o_load_cnt = MEM_DEPTH. Assert i_reset mid-RUN: all outputs return to reset values asynchronously.
